// File: rtl/di_latency_terminal.sv
// di_latency_terminal
// Simulation terminal on the HostInterface device-interface bus. Holds a
// DEPTH-word register file and answers transfers with a per-transfer
// programmable read/write latency: wait 0 is always-ready, wait N stalls
// N cycles, wait 8'hFF never becomes ready again. Sticky status flags
// report out-of-range accesses and never-ready loads.
//
// Ports:
//   ifclk, reset         bus clock, synchronous active-high reset
//   di_term_addr         terminal address; sel = (di_term_addr == TERM_ADDR)
//   di_reg_addr          transfer start word address
//   di_read_mode/_write_mode  high for the duration of a transfer
//   di_read_req          one-cycle request for the next read word
//   di_read / di_write   read / write strobes
//   di_reg_datai         write data
//   cfg_read_wait        read latency (8'hFF = never ready)
//   cfg_write_wait       post-write busy cycles (8'hFF = never ready)
//   sel                  address match (combinational)
//   di_reg_datao         read data, mem[(di_reg_addr + ofs) mod DEPTH]
//   di_read_rdy/_write_rdy  handshake readies
//   di_transfer_status   {14'b0, stall_forever, range_err}
module di_latency_terminal #(
    parameter logic [15:0] TERM_ADDR  = 16'h0000,
    parameter int          DATA_WIDTH = 16,
    parameter int          DEPTH      = 64,
    parameter int          ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  ifclk,
    input  logic                  reset,
    input  logic [15:0]           di_term_addr,
    input  logic [31:0]           di_reg_addr,
    input  logic                  di_read_mode,
    input  logic                  di_write_mode,
    input  logic                  di_read_req,
    input  logic                  di_read,
    input  logic                  di_write,
    input  logic [DATA_WIDTH-1:0] di_reg_datai,
    input  logic [7:0]            cfg_read_wait,
    input  logic [7:0]            cfg_write_wait,
    output logic                  sel,
    output logic [DATA_WIDTH-1:0] di_reg_datao,
    output logic                  di_read_rdy,
    output logic                  di_write_rdy,
    output logic [15:0]           di_transfer_status
);

    localparam logic [7:0] WAIT_FOREVER = 8'hFF;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [31:0] r_ofs;
    logic [7:0]  r_rd_cnt;
    logic [7:0]  r_wr_cnt;
    logic        r_rd_mode_q;
    logic        r_wr_mode_q;
    logic        r_range_err;
    logic        r_stall_forever;

    logic                  w_sel;
    logic [31:0]           w_ea;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_read_rdy;
    logic                  w_write_rdy;
    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic                  w_start;
    logic                  w_rd_load_ff;
    logic                  w_wr_load_ff;

    assign w_sel       = (di_term_addr == TERM_ADDR);
    // Effective address wraps mod 2^32; the index simply drops the upper
    // bits, so out-of-range addresses alias into the file.
    assign w_ea        = di_reg_addr + r_ofs;
    assign w_idx       = w_ea[ADDR_WIDTH-1:0];

    // The req cycle itself is always masked so a zero wait still costs one
    // cycle between request and data.
    assign w_read_rdy  = w_sel & ~reset & (r_rd_cnt == 8'd0) & ~di_read_req;
    assign w_write_rdy = w_sel & ~reset & (r_wr_cnt == 8'd0);
    assign w_rd_acc    = di_read  & w_read_rdy;
    assign w_wr_acc    = di_write & w_write_rdy;

    assign w_start = w_sel & ((di_read_mode  & ~r_rd_mode_q) |
                              (di_write_mode & ~r_wr_mode_q));

    assign w_rd_load_ff = w_sel & di_read_req & (cfg_read_wait == WAIT_FOREVER);
    assign w_wr_load_ff = w_wr_acc & (cfg_write_wait == WAIT_FOREVER);

    assign sel                = w_sel;
    assign di_reg_datao       = r_mem[w_idx];
    assign di_read_rdy        = w_read_rdy;
    assign di_write_rdy       = w_write_rdy;
    assign di_transfer_status = {14'b0, r_stall_forever, r_range_err};

    // Register file has no reset; contents are X until written.
    always_ff @(posedge ifclk) begin
        if (w_wr_acc) begin
            r_mem[w_idx] <= di_reg_datai;
        end
    end

    always_ff @(posedge ifclk) begin
        if (reset) begin
            r_ofs           <= 32'd0;
            r_rd_cnt        <= 8'd0;
            r_wr_cnt        <= 8'd0;
            r_rd_mode_q     <= 1'b0;
            r_wr_mode_q     <= 1'b0;
            r_range_err     <= 1'b0;
            r_stall_forever <= 1'b0;
        end else begin
            r_rd_mode_q <= di_read_mode;
            r_wr_mode_q <= di_write_mode;

            // Counters only live while selected; 8'hFF is a parking value.
            if (!w_sel) begin
                r_rd_cnt <= 8'd0;
                r_wr_cnt <= 8'd0;
            end else begin
                if (di_read_req) begin
                    r_rd_cnt <= cfg_read_wait;
                end else if (r_rd_cnt != 8'd0 && r_rd_cnt != WAIT_FOREVER) begin
                    r_rd_cnt <= r_rd_cnt - 8'd1;
                end

                if (w_wr_acc) begin
                    r_wr_cnt <= cfg_write_wait;
                end else if (r_wr_cnt != 8'd0 && r_wr_cnt != WAIT_FOREVER) begin
                    r_wr_cnt <= r_wr_cnt - 8'd1;
                end
            end

            // A transfer start wins over any strobe landing in the same cycle.
            if (w_start) begin
                r_ofs           <= 32'd0;
                r_range_err     <= 1'b0;
                r_stall_forever <= 1'b0;
            end else begin
                // Simultaneous read+write strobes still advance by one word.
                if (w_rd_acc | w_wr_acc) begin
                    r_ofs <= r_ofs + 32'd1;
                end
                if ((w_rd_acc | w_wr_acc) && (w_ea >= 32'(DEPTH))) begin
                    r_range_err <= 1'b1;
                end
                if (w_rd_load_ff | w_wr_load_ff) begin
                    r_stall_forever <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_di_latency_terminal.sv
// Self-checking bench for di_latency_terminal: a vector table covering a
// zero-wait write/read stream, then hand-written sequences for slow read,
// never-ready, range aliasing, write stall and reset mid-wait.
module tb_di_latency_terminal;

    localparam logic [15:0] TA = 16'h0005;

    logic        ifclk = 1'b0;
    logic        reset;
    logic [15:0] di_term_addr;
    logic [31:0] di_reg_addr;
    logic        di_read_mode, di_write_mode, di_read_req, di_read, di_write;
    logic [15:0] di_reg_datai;
    logic [7:0]  cfg_read_wait, cfg_write_wait;
    logic        sel;
    logic [15:0] di_reg_datao;
    logic        di_read_rdy, di_write_rdy;
    logic [15:0] di_transfer_status;

    di_latency_terminal #(.TERM_ADDR(TA), .DATA_WIDTH(16), .DEPTH(64)) dut (
        .ifclk(ifclk), .reset(reset), .di_term_addr(di_term_addr),
        .di_reg_addr(di_reg_addr), .di_read_mode(di_read_mode),
        .di_write_mode(di_write_mode), .di_read_req(di_read_req),
        .di_read(di_read), .di_write(di_write), .di_reg_datai(di_reg_datai),
        .cfg_read_wait(cfg_read_wait), .cfg_write_wait(cfg_write_wait),
        .sel(sel), .di_reg_datao(di_reg_datao), .di_read_rdy(di_read_rdy),
        .di_write_rdy(di_write_rdy), .di_transfer_status(di_transfer_status)
    );

    always #5 ifclk = ~ifclk;

    typedef struct {
        logic        rm, wm, req, rd, wr;
        logic [31:0] addr;
        logic [15:0] din;
        logic        e_rr, e_wr, chk_do;
        logic [15:0] e_do;
        logic [15:0] e_st;
    } vec_t;

    vec_t tbl[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic tick();
        @(posedge ifclk);
        #2;
    endtask

    function automatic vec_t mk(input logic rm, wm, req, rd, wr, input logic [15:0] din,
                                input logic e_rr, e_wr, chk_do, input logic [15:0] e_do);
        vec_t v;
        v.rm = rm; v.wm = wm; v.req = req; v.rd = rd; v.wr = wr;
        v.addr = 32'd4; v.din = din;
        v.e_rr = e_rr; v.e_wr = e_wr; v.chk_do = chk_do; v.e_do = e_do;
        v.e_st = 16'h0000;
        return v;
    endfunction

    initial begin
        int lows;
        int k;

        // Zero-wait stream: write 8 words at addr 4, then read them back.
        tbl.push_back(mk(0, 1, 0, 0, 0, 16'h0, 1, 1, 0, 16'h0));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(0, 1, 0, 0, 1, 16'h1000 + 16'(i), 1, 1, 0, 16'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 16'h0, 1, 1, 0, 16'h0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 16'h0, 1, 1, 0, 16'h0));
        for (int i = 0; i < 8; i++) begin
            tbl.push_back(mk(1, 0, 1, 0, 0, 16'h0, 0, 1, 1, 16'h1000 + 16'(i)));
            tbl.push_back(mk(1, 0, 0, 1, 0, 16'h0, 1, 1, 1, 16'h1000 + 16'(i)));
        end
        tbl.push_back(mk(0, 0, 0, 0, 0, 16'h0, 1, 1, 0, 16'h0));

        reset = 1'b1; di_term_addr = TA; di_reg_addr = 32'd4;
        di_read_mode = 0; di_write_mode = 0; di_read_req = 0; di_read = 0; di_write = 0;
        di_reg_datai = 16'h0; cfg_read_wait = 8'd0; cfg_write_wait = 8'd0;

        tick(); tick();
        chk("rst_rrdy", di_read_rdy, 0);
        chk("rst_wrdy", di_write_rdy, 0);
        chk("sel", sel, 1);
        reset = 1'b0;
        tick();
        chk("post_rst_rrdy", di_read_rdy, 1);
        chk("post_rst_wrdy", di_write_rdy, 1);
        chk("post_rst_status", di_transfer_status, 16'h0);

        foreach (tbl[i]) begin
            tick();
            di_read_mode = tbl[i].rm; di_write_mode = tbl[i].wm;
            di_read_req = tbl[i].req; di_read = tbl[i].rd; di_write = tbl[i].wr;
            di_reg_addr = tbl[i].addr; di_reg_datai = tbl[i].din;
            #1;
            chk($sformatf("vec%0d_rrdy", i), di_read_rdy, tbl[i].e_rr);
            chk($sformatf("vec%0d_wrdy", i), di_write_rdy, tbl[i].e_wr);
            chk($sformatf("vec%0d_status", i), di_transfer_status, tbl[i].e_st);
            if (tbl[i].chk_do)
                chk($sformatf("vec%0d_datao", i), di_reg_datao, tbl[i].e_do);
        end

        // Slow read: wait 63 -> ready exactly 64 cycles after req.
        tick(); cfg_read_wait = 8'd63; di_read_mode = 1; di_reg_addr = 32'd4;
        tick(); di_read_req = 1; #1;
        chk("slow_req_cycle_rrdy", di_read_rdy, 0);
        tick(); di_read_req = 0;
        lows = 0;
        for (k = 1; k <= 63; k++) begin
            if (k > 1) tick();
            #1;
            if (di_read_rdy !== 1'b0) lows++;
        end
        chk("slow_early_ready_cycles", lows, 0);
        tick(); #1;
        chk("slow_rrdy_t64", di_read_rdy, 1);
        chk("slow_datao", di_reg_datao, 16'h1000);

        // Never-ready read.
        tick(); cfg_read_wait = 8'hFF; di_read_req = 1;
        tick(); di_read_req = 0;
        lows = 0;
        for (int c = 0; c < 1000; c++) begin
            tick(); #1;
            if (di_read_rdy !== 1'b0) lows++;
        end
        chk("never_ready_cycles", lows, 0);
        chk("never_status", di_transfer_status, 16'h0002);
        tick(); di_read_mode = 0;
        tick(); di_read_mode = 1;
        tick(); #1;
        chk("never_status_cleared", di_transfer_status, 16'h0000);
        chk("never_still_stalled", di_read_rdy, 0);
        tick(); di_term_addr = TA + 16'd1; #1;
        chk("desel_sel", sel, 0);
        chk("desel_rrdy", di_read_rdy, 0);
        chk("desel_wrdy", di_write_rdy, 0);
        tick(); di_term_addr = TA; cfg_read_wait = 8'd0; #1;
        chk("resel_rrdy", di_read_rdy, 1);

        // Range: 4 words at addr 62 alias to 62,63,0,1.
        tick(); di_read_mode = 0;
        tick(); di_write_mode = 1; di_reg_addr = 32'd62;
        for (int i = 0; i < 4; i++) begin
            tick(); di_write = 1; di_reg_datai = 16'h00A0 + 16'(i); #1;
            chk($sformatf("range_wrdy%0d", i), di_write_rdy, 1);
        end
        tick(); di_write = 0; #1;
        chk("range_status", di_transfer_status, 16'h0001);
        tick(); di_write_mode = 0;
        tick(); di_read_mode = 1;
        tick(); #1;
        chk("range_idx62", di_reg_datao, 16'h00A0);
        di_reg_addr = 32'd63; #1;
        chk("range_idx63", di_reg_datao, 16'h00A1);
        di_reg_addr = 32'd0; #1;
        chk("range_idx0", di_reg_datao, 16'h00A2);
        di_reg_addr = 32'd1; #1;
        chk("range_idx1", di_reg_datao, 16'h00A3);

        // Write stall: wait 3, strobe held -> one store per 4 cycles.
        tick(); di_read_mode = 0;
        tick(); di_write_mode = 1; cfg_write_wait = 8'd3; di_reg_addr = 32'd20;
        for (int c = 0; c < 9; c++) begin
            tick(); di_write = 1; di_reg_datai = 16'hB000 + 16'(c); #1;
            chk($sformatf("stall_wrdy_c%0d", c), di_write_rdy, (c % 4 == 0) ? 1 : 0);
        end
        tick(); di_write = 0; di_write_mode = 0;
        tick(); di_read_mode = 1;
        tick(); #1;
        chk("stall_idx20", di_reg_datao, 16'hB000);
        di_reg_addr = 32'd21; #1;
        chk("stall_idx21", di_reg_datao, 16'hB004);
        di_reg_addr = 32'd22; #1;
        chk("stall_idx22", di_reg_datao, 16'hB008);

        // Reset mid-wait, with a sticky range_err set beforehand.
        tick(); di_read_mode = 0; cfg_write_wait = 8'd0;
        tick(); di_write_mode = 1; di_reg_addr = 32'd100;
        tick(); di_write = 1; di_reg_datai = 16'h5555;
        tick(); di_write = 0; #1;
        chk("pre_reset_status", di_transfer_status, 16'h0001);
        tick(); cfg_read_wait = 8'd63; di_read_req = 1;
        tick(); di_read_req = 0;
        for (int c = 0; c < 19; c++) tick();
        #1;
        chk("midwait_rrdy", di_read_rdy, 0);
        tick(); reset = 1; #1;
        chk("inreset_rrdy", di_read_rdy, 0);
        chk("inreset_wrdy", di_write_rdy, 0);
        tick(); #1;
        chk("inreset2_rrdy", di_read_rdy, 0);
        tick(); reset = 0; #1;
        chk("postreset_rrdy", di_read_rdy, 1);
        chk("postreset_wrdy", di_write_rdy, 1);
        chk("postreset_status", di_transfer_status, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
